// File: rtl/vend_pkg.sv
// Shared FSM state type and change constants for the vending dispenser.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, ITEM, COIN, FAULT} state_e;

  localparam logic [1:0] CHG_0 = 2'd0;
  localparam logic [1:0] CHG_1 = 2'd1;
  localparam logic [1:0] CHG_2 = 2'd2;
  localparam logic [1:0] CHG_3 = 2'd3;

  localparam int unsigned COIN_VALUE = 5;

endpackage

// File: rtl/vend_wdog.sv
// Per-action watchdog: counts cycles of a mechanical action and flags the
// TIMEOUT_CYC-th one; only exists when VEND_DISPENSER_WDOG_EN is defined.
`ifdef VEND_DISPENSER_WDOG_EN
module vend_wdog #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic restart_i,
  output logic timeout_o
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_cur;

  // restart_i marks the first cycle of an action, which counts as cycle zero
  assign cnt_cur   = restart_i ? '0 : cnt_q;
  assign timeout_o = active_i && (cnt_cur == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (active_i) begin
      cnt_q <= cnt_cur + CW'(1);
    end else begin
      cnt_q <= '0;
    end
  end
endmodule
`endif

// File: rtl/vend_dispenser.sv
// Vending dispenser: item motor then change coins, 1-cycle vend-to-motor latency, one-deep request buffer.
// Optional watchdog (macro VEND_DISPENSER_WDOG_EN) parks the FSM in FAULT when an action stalls.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned COIN_CAP    = 8,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend,
  input  logic [1:0] change,
  input  logic       item_done,
  input  logic       coin_done,
  input  logic       refill,
  output logic       item_motor,
  output logic       coin_eject,
  output logic       busy,
  output logic [3:0] coin_cnt,
  output logic       short_change,
  output logic       overrun,
  output logic       fault
);
  localparam logic [3:0] CAP = 4'(COIN_CAP);

  state_e     state_q;
  logic [1:0] coins_left_q;
  logic [1:0] pend_chg_q;
  logic       pend_vld_q;
  logic [3:0] coin_cnt_q;
  logic       item_motor_q;
  logic       coin_eject_q;
  logic       short_q;
  logic       overrun_q;
  logic       entry_q;
  logic       timeout;
  logic       to_fault;
  logic [3:0] coin_cnt_d;
  logic [1:0] coins_left_d;

  // Inventory after a paid coin; a coincident refill wins.
  assign coin_cnt_d   = refill ? CAP : coin_cnt_q - 4'd1;
  assign coins_left_d = coins_left_q - 2'd1;
  assign to_fault     = timeout && !(state_q == ITEM ? item_done : (coin_eject_q && coin_done));

`ifdef VEND_DISPENSER_WDOG_EN
  logic wdog_active;
  assign wdog_active = (state_q == ITEM) || (state_q == COIN);

  vend_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .active_i  (wdog_active),
    .restart_i (entry_q),
    .timeout_o (timeout)
  );
  assign fault = (state_q == FAULT);
`else
  logic unused_wdog;
  assign unused_wdog = (TIMEOUT_CYC == 0) ^ entry_q;
  assign timeout     = 1'b0;
  assign fault       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      coins_left_q <= CHG_0;
      pend_chg_q   <= CHG_0;
      pend_vld_q   <= 1'b0;
      coin_cnt_q   <= CAP;
      item_motor_q <= 1'b0;
      coin_eject_q <= 1'b0;
      short_q      <= 1'b0;
      overrun_q    <= 1'b0;
      entry_q      <= 1'b0;
    end else begin
      entry_q <= 1'b0;
      if (state_q == IDLE) begin
        if (pend_vld_q || vend) begin
          state_q      <= ITEM;
          item_motor_q <= 1'b1;
          entry_q      <= 1'b1;
          coins_left_q <= pend_vld_q ? pend_chg_q : change;
        end
        // The buffered request launches now, so a fresh vend takes its slot.
        pend_vld_q <= pend_vld_q && vend;
        if (pend_vld_q && vend) pend_chg_q <= change;
      end else if (vend) begin
        if (pend_vld_q || state_q == FAULT) begin
          overrun_q <= 1'b1;
        end else begin
          pend_vld_q <= 1'b1;
          pend_chg_q <= change;
        end
      end

      case (state_q)
        ITEM: begin
          if (item_done) begin
            item_motor_q <= 1'b0;
            if (coins_left_q != CHG_0 && coin_cnt_q != 4'd0) begin
              state_q      <= COIN;
              coin_eject_q <= 1'b1;
              entry_q      <= 1'b1;
            end else begin
              state_q      <= IDLE;
              coins_left_q <= CHG_0;
              if (coins_left_q != CHG_0) short_q <= 1'b1;
            end
          end
        end
        COIN: begin
          // coin_done only counts while the ejector is driven, so a level
          // held over from the previous coin is ignored in the gap cycle.
          if (coin_eject_q && coin_done) begin
            coin_cnt_q   <= coin_cnt_d;
            coins_left_q <= coins_left_d;
            coin_eject_q <= 1'b0;
            if (coins_left_d != CHG_0 && coin_cnt_d != 4'd0) begin
              entry_q <= 1'b1;
            end else begin
              state_q      <= IDLE;
              coins_left_q <= CHG_0;
              if (coins_left_d != CHG_0) short_q <= 1'b1;
            end
          end else if (!coin_eject_q) begin
            coin_eject_q <= 1'b1;
          end
        end
        default: ;
      endcase

      if (to_fault) begin
        state_q      <= FAULT;
        item_motor_q <= 1'b0;
        coin_eject_q <= 1'b0;
        pend_vld_q   <= 1'b0;
        coins_left_q <= CHG_0;
      end
      if (refill) coin_cnt_q <= CAP;
    end
  end

  assign item_motor   = item_motor_q;
  assign coin_eject   = coin_eject_q;
  assign busy         = (state_q != IDLE) || pend_vld_q;
  assign coin_cnt     = coin_cnt_q;
  assign short_change = short_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: cycle vector table, directed corner sequences,
// and random vend transactions checked against a coin-inventory model.
module tb_vend_dispenser;
  import vend_pkg::*;

  localparam int CAP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vend = 1'b0;
  logic [1:0] change = 2'd0;
  logic       item_done = 1'b0;
  logic       coin_done = 1'b0;
  logic       refill = 1'b0;
  logic       item_motor, coin_eject, busy, short_change, overrun, fault;
  logic [3:0] coin_cnt;

  int n_chk = 0;
  int n_err = 0;
  int m_cnt;
  bit m_short;
  int m_value = 0;

  // One row per clock: inputs applied, then outputs expected after the edge.
  typedef struct {
    logic [5:0] in;   // {vend, change[1:0], item_done, coin_done, refill}
    logic [2:0] oe;   // {item_motor, coin_eject, busy}
    logic [3:0] cnt;
    logic [1:0] fl;   // {short_change, overrun}
  } vec_t;

  vec_t tbl [23];

  vend_dispenser #(.COIN_CAP(CAP), .TIMEOUT_CYC(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .vend         (vend),
    .change       (change),
    .item_done    (item_done),
    .coin_done    (coin_done),
    .refill       (refill),
    .item_motor   (item_motor),
    .coin_eject   (coin_eject),
    .busy         (busy),
    .coin_cnt     (coin_cnt),
    .short_change (short_change),
    .overrun      (overrun),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    vend = 1'b0; change = 2'd0; item_done = 1'b0; coin_done = 1'b0; refill = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_cnt = CAP;
    m_short = 1'b0;
  endtask

  // One vend from idle; the bench acts as the mechanism. Item completes on
  // its di-th motor cycle, each coin on its cd-th eject cycle.
  task automatic run_txn(input logic [1:0] chg, input int di, input int cd, input bit rf_coin, input string tag);
    int c, paid, icnt, ecnt, run, runs, cyc;
    bit done, rf_eff;
    c = int'(chg);
    paid = (c < m_cnt) ? c : m_cnt;
    rf_eff = rf_coin && c > 0 && m_cnt > 0;
    if (rf_eff) begin
      paid = c;
      m_cnt = CAP - (c - 1);
    end else begin
      m_cnt = m_cnt - paid;
    end
    if (paid < c) m_short = 1'b1;
    m_value += paid * COIN_VALUE;

    icnt = 0; ecnt = 0; run = 0; runs = 0; cyc = 0; done = 1'b0;
    vend = 1'b1; change = chg;
    @(negedge clk);
    vend = 1'b0; change = 2'd0;
    while (!done && cyc < 200) begin
      item_done = 1'b0; coin_done = 1'b0; refill = 1'b0;
      if (item_motor === 1'b1) begin
        icnt++;
        if (icnt == di) item_done = 1'b1;
      end
      if (coin_eject === 1'b1) begin
        ecnt++; run++;
        if (run == cd) begin
          coin_done = 1'b1;
          if (rf_coin && runs == 0) refill = 1'b1;
        end
      end else if (run > 0) begin
        runs++; run = 0;
      end
      if (busy === 1'b0 && item_motor === 1'b0 && coin_eject === 1'b0) done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    item_done = 1'b0; coin_done = 1'b0; refill = 1'b0;
    check({tag, ".finished"}, 32'(done), 32'd1);
    check({tag, ".item_cycles"}, icnt, di);
    check({tag, ".eject_cycles"}, ecnt, paid * cd);
    check({tag, ".coins"}, runs, paid);
    check({tag, ".coin_cnt"}, 32'(coin_cnt), m_cnt);
    check({tag, ".short"}, 32'(short_change), 32'(m_short));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int mcnt;
    tbl[0]  = '{6'b1_01_000, 3'b101, 4'd8, 2'b00};
    tbl[1]  = '{6'b0_00_000, 3'b101, 4'd8, 2'b00};
    tbl[2]  = '{6'b0_00_000, 3'b101, 4'd8, 2'b00};
    tbl[3]  = '{6'b0_00_100, 3'b011, 4'd8, 2'b00};
    tbl[4]  = '{6'b0_00_000, 3'b011, 4'd8, 2'b00};
    tbl[5]  = '{6'b0_00_010, 3'b000, 4'd7, 2'b00};
    tbl[6]  = '{6'b0_00_000, 3'b000, 4'd7, 2'b00};
    tbl[7]  = '{6'b1_10_000, 3'b101, 4'd7, 2'b00};
    tbl[8]  = '{6'b1_11_000, 3'b101, 4'd7, 2'b00};
    tbl[9]  = '{6'b1_00_000, 3'b101, 4'd7, 2'b01};
    tbl[10] = '{6'b0_00_100, 3'b011, 4'd7, 2'b01};
    tbl[11] = '{6'b0_00_010, 3'b001, 4'd6, 2'b01};
    tbl[12] = '{6'b0_00_010, 3'b011, 4'd6, 2'b01};
    tbl[13] = '{6'b0_00_000, 3'b011, 4'd6, 2'b01};
    tbl[14] = '{6'b0_00_011, 3'b001, 4'd8, 2'b01};
    tbl[15] = '{6'b0_00_000, 3'b101, 4'd8, 2'b01};
    tbl[16] = '{6'b0_00_100, 3'b011, 4'd8, 2'b01};
    tbl[17] = '{6'b0_00_010, 3'b001, 4'd7, 2'b01};
    tbl[18] = '{6'b0_00_000, 3'b011, 4'd7, 2'b01};
    tbl[19] = '{6'b0_00_010, 3'b001, 4'd6, 2'b01};
    tbl[20] = '{6'b0_00_000, 3'b011, 4'd6, 2'b01};
    tbl[21] = '{6'b0_00_010, 3'b000, 4'd5, 2'b01};
    tbl[22] = '{6'b0_00_000, 3'b000, 4'd5, 2'b01};

    repeat (2) @(negedge clk);
    check("reset.item_motor", 32'(item_motor), 0);
    check("reset.coin_eject", 32'(coin_eject), 0);
    check("reset.busy", 32'(busy), 0);
    check("reset.coin_cnt", 32'(coin_cnt), CAP);
    check("reset.flags", 32'({short_change, overrun, fault}), 0);
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      {vend, change, item_done, coin_done, refill} = tbl[i].in;
      @(negedge clk);
      check($sformatf("vec%0d.motor_eject_busy", i), 32'({item_motor, coin_eject, busy}), 32'(tbl[i].oe));
      check($sformatf("vec%0d.coin_cnt", i), 32'(coin_cnt), 32'(tbl[i].cnt));
      check($sformatf("vec%0d.short_overrun", i), 32'({short_change, overrun}), 32'(tbl[i].fl));
    end
    {vend, change, item_done, coin_done, refill} = 6'b0;

    // Drain the tube down to one coin, then ask for three.
    m_cnt = 5; m_short = 1'b0;
    run_txn(CHG_3, 2, 1, 1'b0, "drain3");
    run_txn(CHG_1, 1, 2, 1'b0, "drain1");
    run_txn(CHG_3, 1, 1, 1'b0, "short_last_coin");
    run_txn(CHG_2, 2, 1, 1'b0, "empty_tube");

    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    m_cnt = CAP;
    check("refill.coin_cnt", 32'(coin_cnt), CAP);

    // Asynchronous reset in the middle of a coin ejection.
    vend = 1'b1; change = CHG_2;
    @(negedge clk);
    vend = 1'b0; change = 2'd0; item_done = 1'b1;
    @(negedge clk);
    item_done = 1'b0;
    check("midcoin.eject_before", 32'(coin_eject), 1);
    #2 rst = 1'b0;
    #1;
    check("midcoin.eject_async", 32'(coin_eject), 0);
    check("midcoin.coin_cnt", 32'(coin_cnt), CAP);
    check("midcoin.flags", 32'({short_change, overrun}), 0);
    check("midcoin.busy", 32'(busy), 0);
    @(negedge clk);
    vend = 1'b1; change = CHG_0; rst = 1'b1;
    @(negedge clk);
    vend = 1'b0;
    check("first_vend.motor", 32'(item_motor), 1);
    item_done = 1'b1;
    @(negedge clk);
    item_done = 1'b0;
    check("first_vend.idle", 32'({busy, item_motor, coin_eject}), 0);
    m_cnt = CAP; m_short = 1'b0;

    // Refill coincident with a coin payment at coin_cnt = 3.
    run_txn(CHG_3, 1, 1, 1'b0, "pre_refill_a");
    run_txn(CHG_2, 2, 1, 1'b0, "pre_refill_b");
    run_txn(CHG_1, 1, 2, 1'b1, "refill_vs_coin");

    vend = 1'b1; change = CHG_0;
    @(negedge clk);
    vend = 1'b0;
`ifdef VEND_DISPENSER_WDOG_EN
    mcnt = 0;
    for (int k = 0; k < 30 && item_motor === 1'b1; k++) begin
      mcnt++;
      @(negedge clk);
    end
    check("wdog.motor_cycles", mcnt, 10);
    check("wdog.fault", 32'(fault), 1);
    check("wdog.motor_off", 32'(item_motor), 0);
    vend = 1'b1;
    @(negedge clk);
    vend = 1'b0;
    check("wdog.overrun", 32'(overrun), 1);
    check("wdog.fault_held", 32'(fault), 1);
`else
    mcnt = 0;
    repeat (30) begin
      if (item_motor === 1'b1) mcnt++;
      @(negedge clk);
    end
    check("stall.motor_cycles", mcnt, 30);
    check("stall.fault", 32'(fault), 0);
    item_done = 1'b1;
    @(negedge clk);
    item_done = 1'b0;
    check("stall.idle", 32'(busy), 0);
`endif

    do_reset();
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        m_cnt = CAP;
        check($sformatf("rnd%0d.refill", t), 32'(coin_cnt), CAP);
      end
      run_txn(2'($urandom_range(0, 3)), int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
              ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", t));
    end

    $display("change value paid by model: %0d", m_value);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vend_dispenser.md
VEND_DISPENSER -- requirements
Module: vend_dispenser

Interface
REQ-001 Parameter COIN_CAP, default 8: change-coin tube capacity; loaded into inventory on refill (1..15).
REQ-002 Parameter TIMEOUT_CYC, default 1000: watchdog limit in clk cycles per mechanical action (used only with REQ-030).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 vend  input  1  one-cycle request pulse: dispense one item.
REQ-006 change  input  2  change coin count sampled with vend: 00=0, 01=1, 10=2, 11=3 coins of 5.
REQ-007 item_done  input  1  item mechanism complete; level, sampled each cycle.
REQ-008 coin_done  input  1  coin ejector complete; level, sampled each cycle.
REQ-009 refill  input  1  one-cycle pulse: coin tube refilled.
REQ-010 item_motor  output  1  drive item motor; high while in ITEM.
REQ-011 coin_eject  output  1  drive coin ejector; high while in COIN.
REQ-012 busy  output  1  high whenever state != IDLE or pending request held.
REQ-013 coin_cnt  output  4  current change-coin inventory.
REQ-014 short_change  output  1  sticky: a requested coin was not paid for lack of inventory.
REQ-015 overrun  output  1  sticky: a vend request was dropped.
REQ-016 fault  output  1  watchdog fault flag (constant 0 without REQ-030).

Function
REQ-017 States SHALL be IDLE, ITEM, COIN, FAULT.
REQ-018 IDLE: vend=1 -> ITEM next cycle, latch change into coins_left; item_motor high first cycle in ITEM (1-cycle latency).
REQ-019 ITEM: item_done=1 -> COIN if coins_left>0 and coin_cnt>0, else IDLE; item_motor low from the following cycle.
REQ-020 COIN: coin_done=1 -> decrement coin_cnt and coins_left; stay in COIN (coin_eject deasserted for exactly one cycle between coins) if both still >0, else IDLE.
REQ-021 If coins_left>0 when coin_cnt reaches 0 or is 0 on leaving ITEM, short_change SHALL set and the unpaid remainder is discarded.
REQ-022 One-deep pending buffer: vend while not IDLE and buffer empty -> store {change}; buffered request starts ITEM the cycle after return to IDLE.
REQ-023 vend while not IDLE and buffer full -> request dropped, overrun set; stored request unchanged.
REQ-024 vend in the same cycle the FSM returns to IDLE SHALL be buffered, not dropped, unless buffer full.
REQ-025 refill SHALL set coin_cnt to COIN_CAP next cycle; refill coinciding with a coin_done decrement: refill wins (coin_cnt=COIN_CAP).
REQ-026 short_change and overrun clear only on reset.
REQ-027 item_done/coin_done SHALL be ignored outside ITEM/COIN respectively.

Reset
REQ-028 rst low SHALL immediately force IDLE, empty buffer, coins_left=0, coin_cnt=COIN_CAP, all outputs except coin_cnt to 0, including mid-ITEM/COIN (motor drops asynchronously).
REQ-029 First vend honoured is the one sampled on the first posedge after rst deasserts.

Configuration
REQ-030 Macro VEND_DISPENSER_WDOG_EN defined: cycle counter runs in ITEM/COIN, clears on each state entry; reaching TIMEOUT_CYC -> FAULT, fault=1, motors off, pending buffer cleared; FAULT exits only by reset; vend in FAULT sets overrun.
REQ-031 Macro undefined: no counter, FAULT unreachable, fault tied 0, TIMEOUT_CYC unused.

Structure
REQ-032 Shared package vend_pkg SHALL hold state enum (IDLE/ITEM/COIN/FAULT), change-code constants (CHG_0..CHG_3) and coin value constant (5).
REQ-033 Sub-module vend_wdog (counter + compare) SHALL be instantiated only under VEND_DISPENSER_WDOG_EN.

Verification
REQ-034 vend, change=01, item_done after 3 cycles, coin_done after 2 -> item_motor 3 cycles, coin_eject 2 cycles, coin_cnt 8->7, busy low after.
REQ-035 coin_cnt=1, vend change=11 -> one coin paid, coin_cnt=0, short_change=1, return IDLE.
REQ-036 Two vends during ITEM -> first buffered and served after first cycle back in IDLE, second dropped, overrun=1.
REQ-037 rst low mid-COIN -> coin_eject 0 same cycle, coin_cnt=COIN_CAP, flags 0.
REQ-038 WDOG_EN, TIMEOUT_CYC=10, item_done never -> FAULT on 10th ITEM cycle, fault=1, item_motor 0; later vend sets overrun.
REQ-039 refill coincident with coin_done at coin_cnt=3 -> coin_cnt=COIN_CAP.
